// File: rtl/mole_scheduler_if.sv
// Purpose: bundles the mole_scheduler game-side inputs and scoring outputs into one port.
// Latency: none, wires only.
// Backpressure: none; every signal is a level or a single-cycle pulse.
// Ports: tick_ms/start/random_value/difficulty/whack drive the scheduler;
//        mole_positions, hit/hit_count/miss/whiff pulses, totals and round status come back.
interface mole_scheduler_if;
    logic        tick_ms;
    logic        start;
    logic [10:0] random_value;
    logic [2:0]  difficulty;
    logic [8:0]  whack;
    logic [8:0]  mole_positions;
    logic        hit;
    logic [3:0]  hit_count;
    logic        miss;
    logic        whiff;
    logic [7:0]  hit_total;
    logic [7:0]  miss_total;
    logic        round_active;
    logic        round_done;

    modport master (
        output tick_ms, start, random_value, difficulty, whack,
        input  mole_positions, hit, hit_count, miss, whiff,
               hit_total, miss_total, round_active, round_done
    );

    modport slave (
        input  tick_ms, start, random_value, difficulty, whack,
        output mole_positions, hit, hit_count, miss, whiff,
               hit_total, miss_total, round_active, round_done
    );
endinterface

// File: rtl/mole_scheduler.sv
// Purpose: whack-a-mole round scheduler: spawns moles after random gaps, ages them, scores whacks.
// Latency: all outputs registered; hit/miss/whiff/hit_count appear the cycle after the causing input.
// Backpressure: none; spawning stalls internally while the concurrent-mole limit is reached.
// Ports: clk, reset (sync, active-high); bus (slave modport) carries game inputs and score outputs.
module mole_scheduler #(
    parameter int ROUND_MOLES = 20,
    parameter int HOLES       = 9
) (
    input  logic            clk,
    input  logic            reset,
    mole_scheduler_if.slave bus
);
    typedef enum logic [2:0] {S_IDLE, S_GAP, S_SPAWN, S_DRAIN, S_DONE} state_t;

    typedef struct packed {
        logic [10:0] gap_base;
        logic [10:0] life;
        logic [3:0]  max_up;
    } diff_cfg_t;

    function automatic diff_cfg_t decode_diff(input logic [2:0] d);
        diff_cfg_t c;
        case (d)
            3'b001:  c = '{gap_base: 11'd800, life: 11'd1200, max_up: 4'd1};
            3'b010:  c = '{gap_base: 11'd600, life: 11'd900,  max_up: 4'd2};
            3'b100:  c = '{gap_base: 11'd400, life: 11'd600,  max_up: 4'd3};
            default: c = '{gap_base: 11'd700, life: 11'd1000, max_up: 4'd2};
        endcase
        return c;
    endfunction

    function automatic logic [3:0] popcount(input logic [HOLES-1:0] v);
        logic [3:0] n;
        n = '0;
        for (int i = 0; i < HOLES; i++) n = n + {3'b000, v[i]};
        return n;
    endfunction

    state_t             state_q, state_d;
    logic [2:0]         diff_q, diff_d;
    logic [5:0]         spawns_left_q, spawns_left_d;
    logic [10:0]        gap_cnt_q, gap_cnt_d;
    logic [10:0]        life_q [HOLES];
    logic [10:0]        life_d [HOLES];
    logic [HOLES-1:0]   pos_q, pos_d;
    logic               hit_q, hit_d;
    logic [3:0]         hit_count_q, hit_count_d;
    logic               miss_q, miss_d;
    logic               whiff_q, whiff_d;
    logic [7:0]         hit_total_q, hit_total_d;
    logic [7:0]         miss_total_q, miss_total_d;

    diff_cfg_t          cfg_now, cfg_lat;
    logic [3:0]         cand, up_cnt, hit_n, miss_n, spawn_idx;
    logic [4:0]         probe;
    logic               spawn_found, spawn_en, ev_en;
    logic [HOLES-1:0]   hit_vec, exp_vec, whiff_vec;
    logic [8:0]         sum_h, sum_m;
    logic               unused_rv_hi;

    assign unused_rv_hi = ^bus.random_value[10:8];

    always_comb begin
        state_d       = state_q;
        diff_d        = diff_q;
        spawns_left_d = spawns_left_q;
        gap_cnt_d     = gap_cnt_q;
        life_d        = life_q;
        pos_d         = pos_q;
        hit_total_d   = hit_total_q;
        miss_total_d  = miss_total_q;
        hit_d         = 1'b0;
        hit_count_d   = '0;
        miss_d        = 1'b0;
        whiff_d       = 1'b0;
        hit_vec       = '0;
        exp_vec       = '0;
        whiff_vec     = '0;
        hit_n         = '0;
        miss_n        = '0;
        sum_h         = '0;
        sum_m         = '0;
        spawn_en      = 1'b0;
        cfg_now       = decode_diff(bus.difficulty);
        cfg_lat       = decode_diff(diff_q);
        up_cnt        = popcount(pos_q);

        // Fold the 4-bit random candidate onto 0..8, then walk upward (wrapping)
        // to the first hole that is free in the registered occupancy.
        cand = (bus.random_value[3:0] >= 4'd9) ? (bus.random_value[3:0] - 4'd9)
                                               : bus.random_value[3:0];
        spawn_found = 1'b0;
        spawn_idx   = '0;
        probe       = '0;
        for (int k = 0; k < HOLES; k++) begin
            probe = {1'b0, cand} + 5'(k);
            if (probe >= 5'(HOLES)) probe = probe - 5'(HOLES);
            if (!spawn_found && !pos_q[probe[3:0]]) begin
                spawn_found = 1'b1;
                spawn_idx   = probe[3:0];
            end
        end

        case (state_q)
            S_IDLE: if (bus.start) begin
                state_d       = S_GAP;
                diff_d        = bus.difficulty;
                spawns_left_d = 6'(ROUND_MOLES);
                hit_total_d   = '0;
                miss_total_d  = '0;
                gap_cnt_d     = cfg_now.gap_base + {3'b000, bus.random_value[7:0]};
            end
            S_GAP: if (bus.tick_ms) begin
                if (gap_cnt_q == 11'd1) state_d = S_SPAWN;
                else                    gap_cnt_d = gap_cnt_q - 11'd1;
            end
            S_SPAWN: if (up_cnt < cfg_lat.max_up && spawn_found) begin
                spawn_en      = 1'b1;
                spawns_left_d = spawns_left_q - 6'd1;
                if (spawns_left_q == 6'd1) begin
                    state_d = S_DRAIN;
                end else begin
                    state_d   = S_GAP;
                    gap_cnt_d = cfg_lat.gap_base + {3'b000, bus.random_value[7:0]};
                end
            end
            S_DRAIN: if (pos_q == '0) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        // Scoring is suppressed on the DRAIN->DONE edge so that no pulse can land in DONE.
        ev_en = (state_q == S_GAP || state_q == S_SPAWN || state_q == S_DRAIN)
                && (state_d != S_DONE);

        if (ev_en) begin
            for (int i = 0; i < HOLES; i++) begin
                // A whack wins over a same-cycle expiry on the same hole.
                if (bus.whack[i]) begin
                    if (pos_q[i]) begin
                        hit_vec[i] = 1'b1;
                        pos_d[i]   = 1'b0;
                    end else begin
                        whiff_vec[i] = 1'b1;
                    end
                end else if (pos_q[i] && bus.tick_ms) begin
                    if (life_q[i] == 11'd1) begin
                        exp_vec[i] = 1'b1;
                        pos_d[i]   = 1'b0;
                    end else begin
                        life_d[i] = life_q[i] - 11'd1;
                    end
                end
            end
            if (spawn_en) begin
                pos_d[spawn_idx]  = 1'b1;
                life_d[spawn_idx] = cfg_lat.life;
            end
            hit_n        = popcount(hit_vec);
            miss_n       = popcount(exp_vec);
            hit_d        = |hit_vec;
            hit_count_d  = hit_n;
            miss_d       = |exp_vec;
            whiff_d      = |whiff_vec;
            sum_h        = {1'b0, hit_total_q} + {5'b0, hit_n};
            sum_m        = {1'b0, miss_total_q} + {5'b0, miss_n};
            hit_total_d  = sum_h[8] ? 8'hFF : sum_h[7:0];
            miss_total_d = sum_m[8] ? 8'hFF : sum_m[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            diff_q        <= '0;
            spawns_left_q <= '0;
            gap_cnt_q     <= '0;
            life_q        <= '{default: '0};
            pos_q         <= '0;
            hit_q         <= 1'b0;
            hit_count_q   <= '0;
            miss_q        <= 1'b0;
            whiff_q       <= 1'b0;
            hit_total_q   <= '0;
            miss_total_q  <= '0;
        end else begin
            state_q       <= state_d;
            diff_q        <= diff_d;
            spawns_left_q <= spawns_left_d;
            gap_cnt_q     <= gap_cnt_d;
            life_q        <= life_d;
            pos_q         <= pos_d;
            hit_q         <= hit_d;
            hit_count_q   <= hit_count_d;
            miss_q        <= miss_d;
            whiff_q       <= whiff_d;
            hit_total_q   <= hit_total_d;
            miss_total_q  <= miss_total_d;
        end
    end

    assign bus.mole_positions = pos_q;
    assign bus.hit            = hit_q;
    assign bus.hit_count      = hit_count_q;
    assign bus.miss           = miss_q;
    assign bus.whiff          = whiff_q;
    assign bus.hit_total      = hit_total_q;
    assign bus.miss_total     = miss_total_q;
    assign bus.round_active   = (state_q == S_GAP) || (state_q == S_SPAWN) || (state_q == S_DRAIN);
    assign bus.round_done     = (state_q == S_DONE);
endmodule

// File: tb/tb_mole_scheduler.sv
module tb_mole_scheduler;
    localparam int RM      = 3;
    localparam int P_IDLE  = 0;
    localparam int P_GAP   = 1;
    localparam int P_SPAWN = 2;
    localparam int P_DRAIN = 3;
    localparam int P_DONE  = 4;

    logic clk;
    logic reset;
    mole_scheduler_if bus();

    mole_scheduler #(.ROUND_MOLES(RM), .HOLES(9)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int hc;
        bit mi;
        bit wf;
        bit dn;
        int pos;
        int ht;
        int mt;
    } exp_t;

    exp_t sbq[$];
    int   tests = 0;
    int   fails = 0;

    // Reference model: round phase, timers in ticks, per-hole up flags and remaining life.
    int ph = P_IDLE;
    int m_gap, m_left, m_gbase, m_lt, m_max, m_ht, m_mt;
    int m_life [9];
    bit m_up   [9];

    task automatic chk(string nm, logic [31:0] act, logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: actual %0d required %0d", nm, act, req);
        end
    endtask

    task automatic flag_fail(string msg);
        tests++;
        fails++;
        $display("FAIL %s", msg);
    endtask

    function automatic int up_count();
        int n = 0;
        for (int i = 0; i < 9; i++) n += int'(m_up[i]);
        return n;
    endfunction

    function automatic int pos_vec();
        int v = 0;
        for (int i = 0; i < 9; i++) if (m_up[i]) v += (1 << i);
        return v;
    endfunction

    task automatic model_step();
        int   nph, sh, c, h, hits, misses;
        bit   wf;
        exp_t e;
        if (reset) begin
            ph = P_IDLE;
            for (int i = 0; i < 9; i++) begin m_up[i] = 0; m_life[i] = 0; end
            m_ht = 0;
            m_mt = 0;
            return;
        end
        if (ph == P_IDLE) begin
            if (bus.start) begin
                case (bus.difficulty)
                    3'b001:  begin m_gbase = 800; m_lt = 1200; m_max = 1; end
                    3'b010:  begin m_gbase = 600; m_lt = 900;  m_max = 2; end
                    3'b100:  begin m_gbase = 400; m_lt = 600;  m_max = 3; end
                    default: begin m_gbase = 700; m_lt = 1000; m_max = 2; end
                endcase
                m_left = RM;
                m_ht   = 0;
                m_mt   = 0;
                m_gap  = m_gbase + int'(bus.random_value) % 256;
                ph     = P_GAP;
            end
            return;
        end
        if (ph == P_DONE) begin
            ph = P_IDLE;
            return;
        end
        nph = ph;
        sh  = -1;
        if (ph == P_GAP) begin
            if (bus.tick_ms) begin
                if (m_gap == 1) nph = P_SPAWN;
                else            m_gap--;
            end
        end else if (ph == P_SPAWN) begin
            if (up_count() < m_max) begin
                c = int'(bus.random_value) % 16;
                if (c >= 9) c -= 9;
                for (int k = 0; k < 9; k++) begin
                    h = (c + k) % 9;
                    if (sh < 0 && !m_up[h]) sh = h;
                end
                m_left--;
                if (m_left == 0) nph = P_DRAIN;
                else begin
                    nph   = P_GAP;
                    m_gap = m_gbase + int'(bus.random_value) % 256;
                end
            end
        end else begin
            if (up_count() == 0) nph = P_DONE;
        end
        hits   = 0;
        misses = 0;
        wf     = 0;
        if (nph != P_DONE) begin
            for (int i = 0; i < 9; i++) begin
                if (bus.whack[i]) begin
                    if (m_up[i]) begin m_up[i] = 0; hits++; end
                    else wf = 1;
                end else if (m_up[i] && bus.tick_ms) begin
                    if (m_life[i] == 1) begin m_up[i] = 0; misses++; end
                    else m_life[i]--;
                end
            end
            if (sh >= 0) begin m_up[sh] = 1; m_life[sh] = m_lt; end
            m_ht = (m_ht + hits > 255)   ? 255 : m_ht + hits;
            m_mt = (m_mt + misses > 255) ? 255 : m_mt + misses;
        end
        ph = nph;
        if (hits > 0 || misses > 0 || wf || nph == P_DONE) begin
            e.hc  = hits;
            e.mi  = (misses > 0);
            e.wf  = wf;
            e.dn  = (nph == P_DONE);
            e.pos = pos_vec();
            e.ht  = m_ht;
            e.mt  = m_mt;
            sbq.push_back(e);
        end
    endtask

    always @(posedge clk) model_step();

    // Monitor: any DUT pulse or any pending expectation forces a cycle-exact comparison.
    always @(negedge clk) begin : monitor
        exp_t e;
        if (bus.hit || bus.miss || bus.whiff || bus.round_done || sbq.size() != 0) begin
            if (sbq.size() == 0) begin
                flag_fail($sformatf("spurious_event: actual hit=%0b miss=%0b whiff=%0b done=%0b, required no pulse",
                                    bus.hit, bus.miss, bus.whiff, bus.round_done));
            end else begin
                e = sbq.pop_front();
                chk("ev_hit",        32'(bus.hit),            32'(e.hc != 0));
                chk("ev_hit_count",  32'(bus.hit_count),      32'(e.hc));
                chk("ev_miss",       32'(bus.miss),           32'(e.mi));
                chk("ev_whiff",      32'(bus.whiff),          32'(e.wf));
                chk("ev_round_done", 32'(bus.round_done),     32'(e.dn));
                chk("ev_positions",  32'(bus.mole_positions), 32'(e.pos));
                chk("ev_hit_total",  32'(bus.hit_total),      32'(e.ht));
                chk("ev_miss_total", 32'(bus.miss_total),     32'(e.mt));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_random(bit allow_start);
        logic [8:0] wh;
        bit         tk;
        tk = ($urandom_range(0, 7) != 0);
        bus.tick_ms      = tk;
        bus.random_value = 11'($urandom);
        case ($urandom_range(0, 5))
            0:       bus.difficulty = 3'b001;
            1:       bus.difficulty = 3'b010;
            2:       bus.difficulty = 3'b100;
            3:       bus.difficulty = 3'b000;
            4:       bus.difficulty = 3'b011;
            default: bus.difficulty = 3'b111;
        endcase
        bus.start = allow_start && ($urandom_range(0, 63) == 0);
        wh = '0;
        if ($urandom_range(0, 9) == 0) wh[$urandom_range(0, 8)] = 1'b1;
        if ($urandom_range(0, 39) == 0)
            for (int i = 0; i < 9; i++) if (m_up[i]) wh[i] = 1'b1;
        for (int i = 0; i < 9; i++)
            if (m_up[i] && m_life[i] == 1 && tk && $urandom_range(0, 1) == 1) wh[i] = 1'b1;
        bus.whack = wh;
    endtask

    task automatic wait_round_end(int bound);
        int k = 0;
        while (ph != P_IDLE && k < bound) begin k++; cyc(); end
        if (k >= bound) flag_fail("round_end_timeout: round never returned to idle");
        else chk("round_active_after_done", 32'(bus.round_active), 32'd0);
    endtask

    initial begin : driver
        int n;
        reset            = 1'b1;
        bus.tick_ms      = 1'b0;
        bus.start        = 1'b0;
        bus.random_value = '0;
        bus.difficulty   = '0;
        bus.whack        = '0;
        repeat (3) cyc();
        chk("rst_positions",    32'(bus.mole_positions), 32'd0);
        chk("rst_hit",          32'(bus.hit),            32'd0);
        chk("rst_hit_count",    32'(bus.hit_count),      32'd0);
        chk("rst_miss",         32'(bus.miss),           32'd0);
        chk("rst_whiff",        32'(bus.whiff),          32'd0);
        chk("rst_hit_total",    32'(bus.hit_total),      32'd0);
        chk("rst_miss_total",   32'(bus.miss_total),     32'd0);
        chk("rst_round_active", 32'(bus.round_active),   32'd0);
        chk("rst_round_done",   32'(bus.round_done),     32'd0);
        reset = 1'b0;
        cyc();

        // Medium round, fixed random value 5: first mole in hole 5, visible 900 ticks.
        bus.difficulty   = 3'b010;
        bus.random_value = 11'h005;
        bus.tick_ms      = 1'b1;
        bus.start        = 1'b1;
        cyc();
        bus.start      = 1'b0;
        bus.difficulty = 3'b100;
        n = 0;
        while (!bus.mole_positions[5] && n < 3000) begin n++; cyc(); end
        chk("first_spawn_wait", 32'(n), 32'd606);
        chk("first_spawn_pos",  32'(bus.mole_positions), 32'h020);
        n = 0;
        while (bus.mole_positions[5] && n < 3000) begin n++; cyc(); end
        chk("mole_visible_ticks", 32'(n), 32'd900);
        chk("expiry_miss",        32'(bus.miss),       32'd1);
        chk("expiry_miss_total",  32'(bus.miss_total), 32'd1);
        wait_round_end(5000);

        // Hard round, candidate 8: second spawn wraps into hole 0, then a double hit.
        bus.difficulty   = 3'b100;
        bus.random_value = 11'h008;
        bus.start        = 1'b1;
        cyc();
        bus.start = 1'b0;
        n = 0;
        while (bus.mole_positions == '0 && n < 3000) begin n++; cyc(); end
        chk("wrap_first_pos", 32'(bus.mole_positions), 32'h100);
        n = 0;
        while (bus.mole_positions == 9'h100 && n < 3000) begin n++; cyc(); end
        chk("wrap_second_pos", 32'(bus.mole_positions), 32'h101);
        bus.whack = 9'h101;
        cyc();
        bus.whack = '0;
        chk("double_hit",       32'(bus.hit),            32'd1);
        chk("double_hit_count", 32'(bus.hit_count),      32'd2);
        chk("double_hit_pos",   32'(bus.mole_positions), 32'd0);
        chk("double_hit_total", 32'(bus.hit_total),      32'd2);
        wait_round_end(5000);

        // Easy round aborted by reset while in GAP with a mole up.
        bus.difficulty   = 3'b001;
        bus.random_value = 11'($urandom);
        bus.start        = 1'b1;
        cyc();
        bus.start = 1'b0;
        n = 0;
        while (bus.mole_positions == '0 && n < 3000) begin n++; cyc(); end
        bus.whack = bus.mole_positions;
        cyc();
        bus.whack = '0;
        chk("pre_reset_hit_total", 32'(bus.hit_total), 32'd1);
        n = 0;
        while (bus.mole_positions == '0 && n < 3000) begin n++; cyc(); end
        reset = 1'b1;
        cyc();
        chk("abort_positions",    32'(bus.mole_positions), 32'd0);
        chk("abort_round_active", 32'(bus.round_active),   32'd0);
        chk("abort_hit_total",    32'(bus.hit_total),      32'd0);
        chk("abort_miss_total",   32'(bus.miss_total),     32'd0);
        chk("abort_round_done",   32'(bus.round_done),     32'd0);
        reset = 1'b0;
        repeat (20) begin
            bus.whack = 9'($urandom);
            cyc();
        end
        bus.whack = '0;

        // Randomized rounds: random difficulty every cycle, stray starts, random and aimed whacks.
        for (int r = 0; r < 8; r++) begin
            drive_random(1'b0);
            bus.start = 1'b1;
            cyc();
            n = 0;
            while (ph != P_IDLE && n < 15000) begin
                drive_random(1'b1);
                cyc();
                n++;
            end
            bus.start = 1'b0;
            bus.whack = '0;
            if (n >= 15000) flag_fail($sformatf("random_round_%0d_timeout", r));
            else begin
                chk("round_hit_total",  32'(bus.hit_total),  32'(m_ht));
                chk("round_miss_total", 32'(bus.miss_total), 32'(m_mt));
            end
            repeat (5) cyc();
        end

        chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/mole_scheduler.md
MOLE_SCHEDULER -- requirements
Module: mole_scheduler

Interface
REQ-001 Parameter ROUND_MOLES, default 20: mole spawns per round (1..63).
REQ-002 Parameter HOLES, default 9: number of holes; fixed at 9 for this revision.
REQ-003 clk  input  1  system clock, all logic on posedge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 tick_ms  input  1  one-cycle pulse per millisecond; all timing counts these pulses.
REQ-006 start  input  1  edge-detected pulse that begins a round.
REQ-007 random_value  input  11  free-running pseudo-random value, sampled where stated.
REQ-008 difficulty  input  3  one-hot difficulty select: 001 easy, 010 medium, 100 hard; others default.
REQ-009 whack  input  9  switch rising-edge pulses, one bit per hole.
REQ-010 mole_positions  output  9  registered; bit i set means a mole is up in hole i.
REQ-011 hit  output  1  registered one-cycle pulse, at least one up mole whacked.
REQ-012 hit_count  output  4  registered; number of moles hit in the cycle hit is high, else 0.
REQ-013 miss  output  1  registered one-cycle pulse, at least one mole expired unwhacked.
REQ-014 whiff  output  1  registered one-cycle pulse, whack on at least one empty hole.
REQ-015 hit_total  output  8  saturating hits this round.
REQ-016 miss_total  output  8  saturating misses this round.
REQ-017 round_active  output  1  high in GAP, SPAWN, DRAIN.
REQ-018 round_done  output  1  one-cycle pulse in DONE.

Function
REQ-019 FSM states SHALL be: IDLE, GAP, SPAWN, DRAIN, DONE.
REQ-020 IDLE: start -> GAP; latch difficulty, load spawns_left=ROUND_MOLES, clear hit_total/miss_total, load gap counter.
REQ-021 start outside IDLE SHALL be ignored; difficulty changes mid-round SHALL be ignored.
REQ-022 Per latched difficulty: gap base easy 800 / medium 600 / hard 400 / default 700 ms; lifetime 1200/900/600/1000 ms; max concurrent moles 1/2/3/2.
REQ-023 Gap load value SHALL be gap base + random_value[7:0], 11-bit, no overflow possible (max 1055).
REQ-024 GAP: gap counter decrements on tick_ms; tick_ms at counter==1 -> SPAWN.
REQ-025 SPAWN candidate SHALL be random_value[3:0], minus 9 if >=9; if occupied, probe upward with wrap 8->0 to the first free hole, all in one cycle.
REQ-026 SPAWN SHALL stall while up-mole count >= max concurrent; occupancy is judged on registered mole_positions.
REQ-027 On spawn: set bit next cycle, load that hole's lifetime counter, decrement spawns_left; spawns_left reaching 0 -> DRAIN, else -> GAP with fresh gap load.
REQ-028 Each hole has an 11-bit lifetime counter decremented on tick_ms while its mole is up; tick_ms at value 1 clears the bit and counts a miss, so a mole is visible exactly lifetime ticks.
REQ-029 whack[i] with bit i set SHALL clear bit i and count a hit; whack[i] with bit i clear counts a whiff.
REQ-030 Whack and expiry on the same hole in the same cycle SHALL count as a hit only.
REQ-031 Simultaneous hits SHALL sum into hit_count; hit_total/miss_total SHALL add the per-cycle count, saturating at 255.
REQ-032 hit/miss/whiff/hit_count SHALL assert the cycle after the causing input and be 0 in IDLE and DONE.
REQ-033 whack in IDLE/DONE SHALL have no effect.
REQ-034 DRAIN: -> DONE when mole_positions==0; DONE -> IDLE after one cycle; totals hold until next start.

Reset
REQ-035 reset SHALL take priority over all inputs: state IDLE, mole_positions=0, all counters 0, all pulse outputs 0, hit_total=miss_total=0, round_active=0.
REQ-036 reset mid-round SHALL abort the round with no round_done, miss or hit pulse.

Verification
REQ-037 Medium, random_value=11'h005, start -> first spawn after 605 ticks in hole 5; mole_positions=9'h020 for exactly 900 ticks, then miss=1, miss_total=1.
REQ-038 Hard, holes 3 and 7 up, whack=9'h088 in one cycle -> next cycle hit=1, hit_count=2, hit_total+=2, mole_positions bits 3,7 clear.
REQ-039 Easy, one mole up, gap expires -> SPAWN stalls, no second mole until first is hit or expires.
REQ-040 Candidate 15 with holes 6,7,8 occupied -> wraps, spawns in hole 0; candidate 6 with 6,7 occupied -> hole 8.
REQ-041 ROUND_MOLES=2, mole expiring in same cycle as its whack -> hit only; after last mole clears, round_done one pulse, then IDLE.
REQ-042 reset asserted in GAP with moles up -> next cycle IDLE, mole_positions=0, totals 0, no round_done.
